// File: rtl/keypad_pkg.sv
// Shared types and limits for the keypad time-entry path.
package keypad_pkg;

  typedef enum logic [1:0] {
    StReleased,
    StPressCnt,
    StHeld,
    StReleaseCnt
  } deb_state_e;

  localparam logic [1:0] MAX_DIGITS    = 2'd3;
  localparam logic [3:0] MAX_SEC_TENS  = 4'd5;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/keypad_time_encoder_if.sv
// BCD digit bus from the keypad encoder to the display decoder and timer load path.
interface keypad_time_encoder_if;

  logic [3:0] min;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] digit_count;
  logic       key_accept;
  logic       key_error;
  logic       time_valid;

  modport master (
    output min, sec_tens, sec_ones, digit_count, key_accept, key_error, time_valid
  );

  modport slave (
    input min, sec_tens, sec_ones, digit_count, key_accept, key_error, time_valid
  );

endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus press/release debounce; emits one accept event per press.
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_pressed,
  input  logic [3:0] key_code,
  output logic       accept_evt,
  output logic [3:0] accept_code
);

  localparam logic [15:0] DebMax = 16'(DEBOUNCE_CYCLES);

  // Strobe and code share one synchronizer so they stay aligned.
  logic [4:0] sync1_q, sync2_q;
  logic       sync_pressed;

  deb_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= StReleased;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {key_pressed, key_code};
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_pressed = sync2_q[4];
  assign accept_code  = sync2_q[3:0];
  assign cnt_inc      = (cnt_q == DebMax) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept_evt = 1'b0;
    unique case (state_q)
      StReleased: begin
        if (sync_pressed) begin
          state_d = StPressCnt;
          cnt_d   = '0;
        end
      end
      StPressCnt: begin
        if (!sync_pressed) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_inc == DebMax) begin
          state_d    = StHeld;
          cnt_d      = '0;
          accept_evt = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHeld: begin
        // The first low sample counts toward the release window.
        if (!sync_pressed) begin
          if (DebMax == 16'd1) begin
            state_d = StReleased;
            cnt_d   = '0;
          end else begin
            state_d = StReleaseCnt;
            cnt_d   = 16'd1;
          end
        end
      end
      StReleaseCnt: begin
        if (sync_pressed) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_inc == DebMax) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/keypad_time_encoder.sv
// Keypad-to-BCD time entry: debounced digits shift in right-to-left into min:sec_tens sec_ones.
module keypad_time_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_pressed,
  input  logic [3:0]                   key_code,
  input  logic                         entry_en,
  input  logic                         clear,
  keypad_time_encoder_if.master        bcd
);

  logic       accept_evt;
  logic [3:0] accept_code;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk         (clk),
    .rst         (rst),
    .key_pressed (key_pressed),
    .key_code    (key_code),
    .accept_evt  (accept_evt),
    .accept_code (accept_code)
  );

  logic [3:0] min_q, min_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [1:0] count_q, count_d;
  logic       accept_q, accept_d;
  logic       error_q, error_d;
  logic       valid_q, valid_d;
  logic       entry_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q      <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      count_q    <= '0;
      accept_q   <= 1'b0;
      error_q    <= 1'b0;
      valid_q    <= 1'b1;
      entry_en_q <= 1'b0;
    end else begin
      min_q      <= min_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      count_q    <= count_d;
      accept_q   <= accept_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
      entry_en_q <= entry_en;
    end
  end

  always_comb begin
    min_d      = min_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    count_d    = count_q;
    accept_d   = 1'b0;
    error_d    = 1'b0;
    // Clear (or leaving entry mode) beats a coincident accept, which is dropped.
    if (clear || (entry_en_q && !entry_en)) begin
      min_d      = '0;
      sec_tens_d = '0;
      sec_ones_d = '0;
      count_d    = '0;
    end else if (accept_evt && entry_en) begin
      if (!is_digit(accept_code) || count_q == MAX_DIGITS) begin
        error_d = 1'b1;
      end else begin
        min_d      = sec_tens_q;
        sec_tens_d = sec_ones_q;
        sec_ones_d = accept_code;
        count_d    = count_q + 2'd1;
        accept_d   = 1'b1;
      end
    end
    valid_d = (sec_tens_d <= MAX_SEC_TENS);
  end

  assign bcd.min         = min_q;
  assign bcd.sec_tens    = sec_tens_q;
  assign bcd.sec_ones    = sec_ones_q;
  assign bcd.digit_count = count_q;
  assign bcd.key_accept  = accept_q;
  assign bcd.key_error   = error_q;
  assign bcd.time_valid  = valid_q;

endmodule

// File: doc/keypad_time_encoder.md
# keypad_time_encoder

Converts microwave keypad presses into the three BCD time digits (minutes, seconds-tens, seconds-ones) that drive the 7-segment display decoder. It is the producer end of the BCD digit bus: it synchronizes and debounces the raw key strobe, accepts one digit per press, and shifts digits in right-to-left, like a microwave front panel. It sits between the keypad scanner and both the display decoder and the countdown timer load path.

## Interface

- DEBOUNCE_CYCLES, default 4: consecutive synchronized-stable cycles required to accept a press or a release. Legal range 1..65535; the board top overrides it.
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- key_pressed  input  1  raw, asynchronous level from the keypad scanner; high while any key is held.
- key_code  input  4  raw code of the held key. 0-9 are digits; 10-15 are non-digit keys. Stable while key_pressed is high.
- entry_en  input  1  entry allowed (oven idle); synchronous.
- clear  input  1  synchronous clear of all digits.
- min  output  4  BCD minutes digit.
- sec_tens  output  4  BCD seconds-tens digit.
- sec_ones  output  4  BCD seconds-ones digit.
- digit_count  output  2  digits entered so far, 0..3.
- key_accept  output  1  one-cycle pulse when a digit is shifted in.
- key_error  output  1  one-cycle pulse on an accepted press that is rejected.
- time_valid  output  1  high when sec_tens <= 5.

## Operation

- Synchronizer: key_pressed and key_code pass through the same two-flop stage. The synchronized code is used at acceptance.
- Debounce FSM with four states: RELEASED, PRESS_CNT, HELD, RELEASE_CNT.
  - RELEASED goes to PRESS_CNT when sync_pressed is high.
  - PRESS_CNT returns to RELEASED if sync_pressed drops, which also zeroes the counter. It goes to HELD once the counter reaches DEBOUNCE_CYCLES, and fires an accept event.
  - HELD goes to RELEASE_CNT when sync_pressed is low.
  - RELEASE_CNT returns to HELD if sync_pressed rises. It goes to RELEASED after DEBOUNCE_CYCLES low cycles.
  - Each physical press produces exactly one accept event.
- The entry FSM acts on an accept event:
  - If entry_en is low, the event is ignored silently and no pulses fire.
  - If the code is greater than 9, or digit_count is 3, the event pulses key_error and changes no digits.
  - Otherwise the digits shift: min takes sec_tens, sec_tens takes sec_ones, sec_ones takes the code. digit_count increments and key_accept pulses.
- clear, or entry_en falling, zeroes all digits and digit_count. It does not disturb the debounce FSM. clear wins over a simultaneous accept event: the event is dropped with no pulses.
- time_valid is registered and recomputed from the next-state sec_tens. For example, entering 7,0 gives sec_tens=7 and time_valid=0. The timer refuses to start on time_valid=0; this block does not correct the value.
- Leading-zero handling belongs to the display decoder. This block always outputs true BCD zeros.

## Timing

- Reset values: all digits 0, digit_count 0, key_accept 0, key_error 0, time_valid 1. Both FSMs return to their idle states and the debounce counter is 0.
- Latency: key_pressed rises before edge k and stays high. The accept event, and the digit, count and pulse updates, are visible after edge k+2+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles are never accepted.
- key_accept and key_error are mutually exclusive and never last more than one cycle.
- Reset asserted mid-debounce or mid-entry takes effect immediately. A key still held when reset releases is accepted once, after the full latency from reset deassertion.
- The debounce counter saturates at DEBOUNCE_CYCLES and never wraps.

## Structure

- Shared package keypad_pkg holds:
  - the debounce state enum;
  - MAX_DIGITS = 3;
  - MAX_SEC_TENS = 5;
  - KEY_DIGIT_MAX = 9.
- Sub-module key_debouncer holds the synchronizer, the debounce FSM and the counter. Its outputs are accept_evt and accept_code.
- keypad_time_encoder instantiates key_debouncer and contains the entry FSM and the digit registers.

## Test plan

- Reset, DEBOUNCE_CYCLES=4, entry_en=1. Press 1, then 3, then 0 with clean releases. Required: key_accept pulses 3 times, final min=1, sec_tens=3, sec_ones=0, digit_count=3, time_valid=1, and each pulse arrives 6 cycles after its key_pressed rise.
- key_pressed glitches high for 3 cycles, then a bounce of 2 high / 1 low / 5 high. Required: exactly one key_accept.
- After three digits, a fourth press of 5 and a press of code 12. Required: two key_error pulses, digits unchanged, digit_count=3.
- Enter 8,0. Required: sec_tens=8, sec_ones=0, time_valid=0. Then clear is asserted in the same cycle as the next accept event. Required: all digits 0, digit_count=0, time_valid=1, no key_accept.
- Press held while entry_en=0, then entry_en rises. Required: no accept for that press; the next press is accepted. Also: rst asserted during PRESS_CNT with a key held. Required: outputs reset immediately, and one accept arrives 2+DEBOUNCE_CYCLES cycles after rst falls.
